// File: rtl/gups_mem_responder_if.sv
// Request/response bus between the GUPS initiator (master) and the memory
// responder (slave). One transaction is outstanding at a time.
interface gups_mem_responder_if;
  logic [63:0] address;
  logic        req;
  logic        wr;
  logic [63:0] data_in;
  logic [63:0] dout;
  logic        ready;

  modport master (
    output address, req, wr, data_in,
    input  dout, ready
  );

  modport slave (
    input  address, req, wr, data_in,
    output dout, ready
  );
endinterface

// File: rtl/gups_mem_responder.sv
// Memory-side responder for the GUPS update engine. Serves single-word
// reads (fixed latency) and writes (one cycle) from an internal 64-bit store,
// zero-fills the store after reset and keeps read/write statistics.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   INIT      | zero-filling the store, one word per edge; req ignored
//   IDLE      | sampling req/wr/address/data_in on every edge
//   READ_WAIT | counting down the remaining read latency
//   RESP      | ready pulse; one-cycle turnaround back to IDLE
module gups_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4   // 1..15, counted from the sampling edge inclusive
) (
  input  logic                  clk,
  input  logic                  reset,      // active-low, asynchronous
  gups_mem_responder_if.slave   bus,
  output logic                  init_done,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  oor_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [63:0]        mem [DEPTH];

  logic [ADDR_W-1:0]  init_idx;
  logic [ADDR_W-1:0]  idx_q;
  logic               wr_q;
  logic               oor_q;
  logic [3:0]         wait_cnt;
  logic [63:0]        dout_q;
  logic [31:0]        rd_count_q;
  logic [31:0]        wr_count_q;
  logic               init_done_q;
  logic               oor_err_q;

  logic [ADDR_W-1:0]  addr_idx;
  logic               addr_oor;
  logic               sample;
  logic               init_last;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [63:0]        mem_wdata;
  logic               rd_fire;
  logic [ADDR_W-1:0]  rd_idx;
  logic               rd_oor;
  logic [63:0]        rd_data;

  assign addr_idx  = bus.address[ADDR_W-1:0];
  assign addr_oor  = |bus.address[63:ADDR_W];
  assign sample    = (state == IDLE) && bus.req;
  assign init_last = (init_idx == {ADDR_W{1'b1}});

  // Store write port: zero-fill during INIT, in-range writes at the IDLE sampling edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_idx;
    mem_wdata = 64'h0;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_idx;
      mem_wdata = 64'h0;
    end else if (sample && bus.wr && !addr_oor) begin
      mem_we    = 1'b1;
      mem_waddr = addr_idx;
      mem_wdata = bus.data_in;
    end
  end

  // Read capture: immediate for single-cycle latency, otherwise at the end of the countdown.
  // With LATENCY=1 the read is taken from the live bus; later it comes from the latched index.
  always_comb begin
    rd_fire = 1'b0;
    rd_idx  = idx_q;
    rd_oor  = oor_q;
    if (state == IDLE) begin
      rd_fire = (LATENCY == 1) && bus.req && !bus.wr;
      rd_idx  = addr_idx;
      rd_oor  = addr_oor;
    end else if (state == READ_WAIT) begin
      rd_fire = (wait_cnt == 4'd1);
    end
    rd_data = rd_oor ? 64'h0 : mem[rd_idx];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      INIT: begin
        if (init_last) state_nx = IDLE;
      end
      IDLE: begin
        if (bus.req) begin
          if (bus.wr || (LATENCY == 1)) state_nx = RESP;
          else                          state_nx = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (wait_cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nx;
  end

  // Zero-fill progress and completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_idx    <= '0;
      init_done_q <= 1'b0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_last) init_done_q <= 1'b1;
    end
  end

  // Transaction latch and read-latency countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      wait_cnt <= 4'd0;
    end else if (sample) begin
      idx_q    <= addr_idx;
      wr_q     <= bus.wr;
      oor_q    <= addr_oor;
      wait_cnt <= 4'(LATENCY - 1);
    end else if (state == READ_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read data register; holds its value across writes and idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       dout_q <= 64'h0;
    else if (rd_fire) dout_q <= rd_data;
  end

  // Statistics and sticky out-of-range flag; counters bump as RESP retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q <= 32'h0;
      wr_count_q <= 32'h0;
      oor_err_q  <= 1'b0;
    end else begin
      if (sample && addr_oor) oor_err_q <= 1'b1;
      if (state == RESP) begin
        if (wr_q) wr_count_q <= wr_count_q + 32'h1;
        else      rd_count_q <= rd_count_q + 32'h1;
      end
    end
  end

  // Word store; no reset, contents are defined by the post-reset zero-fill.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dout  = dout_q;
  assign bus.ready = (state == RESP);
  assign init_done = init_done_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign oor_err   = oor_err_q;

endmodule

// File: tb/tb_gups_mem_responder.sv
// Self-checking bench for gups_mem_responder with ADDR_W=4, LATENCY=3.
// Latency is counted in edges from the sampling edge inclusive: a write shows
// ready after 1 edge, a read after 3.
module tb_gups_mem_responder;

  localparam int ADDR_W  = 4;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        oor_err;

  int n_checks = 0;
  int n_fail   = 0;

  gups_mem_responder_if bus ();

  gups_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .init_done (init_done),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .oor_err   (oor_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [63:0] dout;
    int          lat;
  } sb_t;

  typedef struct {
    logic        w;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_dout;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    logic        exp_oor;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; inputs are scrambled after the sampling edge.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] ed, input int lat);
    int  edges;
    sb_t e;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.address = a; bus.data_in = d;
    sb_q.push_back('{w: w, dout: ed, lat: lat});
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.req = 1'b0;
    bus.wr = 1'($urandom);
    bus.address = a ^ 64'h1;
    bus.data_in = {$urandom, $urandom};
    while (!bus.ready && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    e = sb_q.pop_front();
    check("ready_seen", 64'(bus.ready), 64'h1);
    check("latency", 64'(edges), 64'(e.lat));
    check(e.w ? "dout_after_wr" : "rd_dout", bus.dout, e.dout);
    @(negedge clk);
    check("ready_single", 64'(bus.ready), 64'h0);
    check("dout_hold", bus.dout, e.dout);
  endtask

  task automatic wait_init(input string tag);
    int edges = 0;
    while (!init_done && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check({tag, "_init_edges"}, 64'(edges), 64'd16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     64'(bus.ready), 64'h0);
    check({tag, "_dout"},      bus.dout,       64'h0);
    check({tag, "_init_done"}, 64'(init_done), 64'h0);
    check({tag, "_rd_count"},  64'(rd_count),  64'h0);
    check({tag, "_wr_count"},  64'(wr_count),  64'h0);
    check({tag, "_oor_err"},   64'(oor_err),   64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, rdy_cnt, first_rdy, init_edge;

    vecs[0]  = '{1'b0, 64'h5,                    64'h0,                   64'h0,                   32'd1,  32'd0, 1'b0};
    vecs[1]  = '{1'b0, 64'h7,                    64'h0,                   64'h0,                   32'd2,  32'd0, 1'b0};
    vecs[2]  = '{1'b1, 64'h7,                    64'h1,                   64'h0,                   32'd2,  32'd1, 1'b0};
    vecs[3]  = '{1'b0, 64'h7,                    64'h0,                   64'h1,                   32'd3,  32'd1, 1'b0};
    vecs[4]  = '{1'b1, 64'h3,                    64'hDEAD_BEEF_0123_4567, 64'h1,                   32'd3,  32'd2, 1'b0};
    vecs[5]  = '{1'b0, 64'h3,                    64'h0,                   64'hDEAD_BEEF_0123_4567, 32'd4,  32'd2, 1'b0};
    vecs[6]  = '{1'b1, 64'h10,                   64'hAB,                  64'hDEAD_BEEF_0123_4567, 32'd4,  32'd3, 1'b1};
    vecs[7]  = '{1'b0, 64'h0,                    64'h0,                   64'h0,                   32'd5,  32'd3, 1'b1};
    vecs[8]  = '{1'b0, 64'h10,                   64'h0,                   64'h0,                   32'd6,  32'd3, 1'b1};
    vecs[9]  = '{1'b1, 64'h13,                   64'h55,                  64'h0,                   32'd6,  32'd4, 1'b1};
    vecs[10] = '{1'b0, 64'h3,                    64'h0,                   64'hDEAD_BEEF_0123_4567, 32'd7,  32'd4, 1'b1};
    vecs[11] = '{1'b1, 64'hF,                    64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0123_4567, 32'd7,  32'd5, 1'b1};
    vecs[12] = '{1'b0, 64'hF,                    64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 32'd8,  32'd5, 1'b1};
    vecs[13] = '{1'b0, 64'h8000_0000_0000_0007,  64'h0,                   64'h0,                   32'd9,  32'd5, 1'b1};
    vecs[14] = '{1'b0, 64'h7,                    64'h0,                   64'h1,                   32'd10, 32'd5, 1'b1};

    rst_n = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.address = 64'h0; bus.data_in = 64'h0;
    #12;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("first");

    // Main table: GUPS RMW, out-of-range handling, dout holding across writes.
    foreach (vecs[i]) begin
      txn(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp_dout,
          vecs[i].w ? 1 : LATENCY);
      check($sformatf("v%0d_rd_count", i), 64'(rd_count), 64'(vecs[i].exp_rd));
      check($sformatf("v%0d_wr_count", i), 64'(wr_count), 64'(vecs[i].exp_wr));
      check($sformatf("v%0d_oor_err", i),  64'(oor_err),  64'(vecs[i].exp_oor));
    end

    // req held through INIT is serviced at the first IDLE edge (edge 17).
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 1'b1; bus.wr = 1'b0; bus.address = 64'h2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0; rdy_cnt = 0; first_rdy = 0; init_edge = 0;
    repeat (24) begin
      @(posedge clk); edges++; @(negedge clk);
      if (edges == 17) begin bus.req = 1'b0; bus.address = 64'h3; end
      if (init_done && init_edge == 0) init_edge = edges;
      if (bus.ready) begin
        rdy_cnt++;
        if (first_rdy == 0) first_rdy = edges;
      end
    end
    check("hold_init_edge", 64'(init_edge), 64'd16);
    check("hold_ready_edge", 64'(first_rdy), 64'd19);
    check("hold_ready_count", 64'(rdy_cnt), 64'd1);
    check("hold_dout", bus.dout, 64'h0);
    check("hold_rd_count", 64'(rd_count), 64'd1);

    // Address changes during READ_WAIT must not affect the read (txn flips to 3).
    txn(1'b1, 64'h2, 64'h2222_2222_2222_2222, 64'h0, 1);
    txn(1'b1, 64'h3, 64'h3333_3333_3333_3333, 64'h0, 1);
    txn(1'b0, 64'h2, 64'h0, 64'h2222_2222_2222_2222, LATENCY);

    // Reset during READ_WAIT aborts the read and re-runs the zero-fill.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.address = 64'h3;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midread");
    rdy_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ready) rdy_cnt++;
    end
    rst_n = 1'b1;
    wait_init("reinit");
    check("midread_no_ready", 64'(rdy_cnt), 64'd0);
    txn(1'b0, 64'h3, 64'h0, 64'h0, LATENCY);
    check("reinit_rd_count", 64'(rd_count), 64'd1);
    txn(1'b1, 64'h4, 64'h44, 64'h0, 1);

    // Read counter wrap.
    force dut.rd_count_q = 32'hFFFF_FFFF;
    #1 release dut.rd_count_q;
    #1 check("wrap_preload", 64'(rd_count), 64'hFFFF_FFFF);
    txn(1'b0, 64'h4, 64'h0, 64'h44, LATENCY);
    check("wrap_rd_count", 64'(rd_count), 64'h0);
    check("wrap_wr_count", 64'(wr_count), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
